ram_loader: RTL and testbench

Sequencer that sits directly upstream of the RAM8 memory built from BIT cells. It drives the memory's `IN`/`LOAD`/address inputs to write a stream of words into consecutive addresses starting at 0, or to clear the whole memory to zero. Words arrive over a valid/ready handshake, for example from a boot ROM or a testbench. `DONE` pulses when the sequence completes.

---
 rtl/ram_loader.sv | 175 +++++++++++++++++
 tb/tb_ram_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_loader.sv
// ram_loader: sequences writes into a small RAM, either streaming words from a
// valid/ready source into addresses 0..COUNT-1 or zero-filling every address.
// Optional readback check after each write: define RAM_LOADER_VERIFY_EN.
// All outputs come straight from flops; control outputs are decoded from the
// next state so they line up with the state they describe.
module ram_loader #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic                  CLEAR,
    input  logic [ADDR_WIDTH:0]   COUNT,
    input  logic [WIDTH-1:0]      DIN,
    input  logic                  DIN_VALID,
    output logic                  DIN_READY,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [WIDTH-1:0]      MEM_IN,
    output logic                  MEM_LOAD,
    input  logic [WIDTH-1:0]      MEM_OUT,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERROR
);

    localparam logic [ADDR_WIDTH:0]   DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH:0]   ONE       = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WRITE, S_CLEAR, S_VERIFY, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0]      mem_in_q, mem_in_d;   // doubles as the latched word
    logic                  din_ready_q, din_ready_d;
    logic                  mem_load_q, mem_load_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [ADDR_WIDTH:0]   cnt_sat;
    logic                  handshake;

`ifdef RAM_LOADER_VERIFY_EN
    logic                  clr_q, clr_d;         // VERIFY needs to know which sequence it belongs to
`else
    logic                  unused_mem_out;
    assign unused_mem_out = ^MEM_OUT;
`endif

    assign cnt_sat   = (COUNT > DEPTH) ? DEPTH : COUNT;
    assign handshake = (state_q == S_LOAD) && din_ready_q && DIN_VALID;

    // Next-state, counters and registered-output decode
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        mem_in_d = mem_in_q;
        error_d  = error_q;
`ifdef RAM_LOADER_VERIFY_EN
        clr_d    = clr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (CLEAR) begin
                    state_d  = S_CLEAR;
                    addr_d   = '0;
                    mem_in_d = '0;
                    error_d  = 1'b0;
`ifdef RAM_LOADER_VERIFY_EN
                    clr_d    = 1'b1;
`endif
                end else if (START) begin
                    addr_d  = '0;
                    error_d = 1'b0;
                    if (cnt_sat != '0) begin
                        state_d = S_LOAD;
                        rem_d   = cnt_sat;
`ifdef RAM_LOADER_VERIFY_EN
                        clr_d   = 1'b0;
`endif
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                if (handshake) begin
                    mem_in_d = DIN;
                    state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                rem_d = rem_q - ONE;
`ifdef RAM_LOADER_VERIFY_EN
                state_d = S_VERIFY;   // address held for the readback
`else
                addr_d  = addr_q + 1'b1;
                state_d = (rem_q > ONE) ? S_LOAD : S_DONE;
`endif
            end
            S_CLEAR: begin
`ifdef RAM_LOADER_VERIFY_EN
                state_d = S_VERIFY;
`else
                if (addr_q == LAST_ADDR) state_d = S_DONE;
                else                     addr_d  = addr_q + 1'b1;
`endif
            end
            S_VERIFY: begin
`ifdef RAM_LOADER_VERIFY_EN
                // mem_in_q still holds the word just written (0 for a clear)
                if (MEM_OUT != mem_in_q) error_d = 1'b1;
                addr_d = addr_q + 1'b1;
                if (clr_q) state_d = (addr_q == LAST_ADDR) ? S_DONE : S_CLEAR;
                else       state_d = (rem_q != '0) ? S_LOAD : S_DONE;
`else
                state_d = S_IDLE;
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        din_ready_d = (state_d == S_LOAD);
        mem_load_d  = (state_d == S_WRITE) || (state_d == S_CLEAR);
        busy_d      = (state_d == S_LOAD) || (state_d == S_WRITE) ||
                      (state_d == S_CLEAR) || (state_d == S_VERIFY);
        done_d      = (state_d == S_DONE);
    end

    // State, counters and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            mem_in_q    <= '0;
            din_ready_q <= 1'b0;
            mem_load_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef RAM_LOADER_VERIFY_EN
            clr_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            mem_in_q    <= mem_in_d;
            din_ready_q <= din_ready_d;
            mem_load_q  <= mem_load_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef RAM_LOADER_VERIFY_EN
            clr_q       <= clr_d;
`endif
        end
    end

    assign DIN_READY = din_ready_q;
    assign MEM_ADDR  = addr_q;
    assign MEM_IN    = mem_in_q;
    assign MEM_LOAD  = mem_load_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ERROR     = error_q;

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: a behavioural 8x16 RAM sits behind the loader; expected
// writes are queued by the stimulus and popped by a monitor on every MEM_LOAD.
module tb_ram_loader;
    localparam int W  = 16;
    localparam int AW = 3;

    logic          CLK = 1'b0;
    logic          RESET, START, CLEAR, DIN_VALID;
    logic [AW:0]   COUNT;
    logic [W-1:0]  DIN;
    logic          DIN_READY, MEM_LOAD, BUSY, DONE, ERROR;
    logic [AW-1:0] MEM_ADDR;
    logic [W-1:0]  MEM_IN, MEM_OUT;

    logic [W-1:0]    ram [8];
    logic            fill_en, corrupt;
    logic [W-1:0]    fill_val;
    logic [AW+W-1:0] exp_q [$];
    logic [AW+W-1:0] e;
    int checks = 0, errors = 0, wr_cnt = 0, done_cnt = 0;

    ram_loader #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .CLEAR(CLEAR), .COUNT(COUNT),
        .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY),
        .MEM_ADDR(MEM_ADDR), .MEM_IN(MEM_IN), .MEM_LOAD(MEM_LOAD),
        .MEM_OUT(MEM_OUT), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR)
    );

    always #5 CLK = ~CLK;

    // Behavioural RAM; address 2 can be made to read back corrupted
    always @(posedge CLK) begin
        if (fill_en) for (int i = 0; i < 8; i++) ram[i] <= fill_val;
        else if (MEM_LOAD) ram[MEM_ADDR] <= MEM_IN;
    end
    assign MEM_OUT = ram[MEM_ADDR] ^ ((corrupt && MEM_ADDR == 3'd2) ? 16'h0040 : 16'h0000);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the head of the expected queue
    always @(negedge CLK) begin
        if (DONE) done_cnt++;
        if (MEM_LOAD) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write: addr %0d data %h, none expected", MEM_ADDR, MEM_IN);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", 32'(MEM_ADDR), 32'(e[AW+W-1:W]));
                chk("write_data", 32'(MEM_IN), 32'(e[W-1:0]));
            end
        end
    end

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic fill(input logic [W-1:0] v);
        fill_val = v; fill_en = 1'b1; tick(); fill_en = 1'b0;
    endtask

    task automatic expect_wr(input int a, input logic [W-1:0] d);
        exp_q.push_back({3'(a), d});
    endtask

    task automatic start_load(input logic [AW:0] c);
        COUNT = c; START = 1'b1; tick(); START = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] w);
        int n = 0;
        DIN = w; DIN_VALID = 1'b1;
        while (!DIN_READY && n < 20) begin tick(); n++; end
        chk("din_ready_wait", 32'(DIN_READY), 32'd1);
        tick();
    endtask

    task automatic wait_done(input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 60) begin tick(); n++; end
        chk("done_seen", 32'(done_cnt - d0), 32'd1);
        tick();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_din_ready"}, 32'(DIN_READY), 0);
        chk({tag, "_mem_addr"},  32'(MEM_ADDR), 0);
        chk({tag, "_mem_in"},    32'(MEM_IN), 0);
        chk({tag, "_mem_load"},  32'(MEM_LOAD), 0);
        chk({tag, "_busy"},      32'(BUSY), 0);
        chk({tag, "_done"},      32'(DONE), 0);
        chk({tag, "_error"},     32'(ERROR), 0);
    endtask

    initial begin
        int w0, d0;
        RESET = 1'b1; START = 1'b0; CLEAR = 1'b0; COUNT = '0; DIN = '0;
        DIN_VALID = 1'b0; fill_en = 1'b0; fill_val = '0; corrupt = 1'b0;
        fill(16'hAAAA);
        tick();
        chk_idle_outputs("reset");
        RESET = 1'b0;
        tick();

        // Load 3 words with DIN_VALID held high
        w0 = wr_cnt; d0 = done_cnt;
        expect_wr(0, 16'h1111); expect_wr(1, 16'h2222); expect_wr(2, 16'h3333);
        start_load(3);
        chk("load3_ready_after_start", 32'(DIN_READY), 1);
        send(16'h1111); send(16'h2222); send(16'h3333);
        DIN_VALID = 1'b0;
`ifndef RAM_LOADER_VERIFY_EN
        tick();
        chk("load3_done_after_last_write", 32'(DONE), 1);
`endif
        wait_done(d0);
        chk("load3_writes", 32'(wr_cnt - w0), 3);
        chk("load3_dones", 32'(done_cnt - d0), 1);
        chk("load3_ram0", 32'(ram[0]), 32'h1111);
        chk("load3_ram2", 32'(ram[2]), 32'h3333);
        chk("load3_ram3_untouched", 32'(ram[3]), 32'hAAAA);
        chk("load3_ram7_untouched", 32'(ram[7]), 32'hAAAA);
        chk("load3_error", 32'(ERROR), 0);

        // Clear over an all-ones RAM, START raised alongside CLEAR
        fill(16'hFFFF);
        w0 = wr_cnt; d0 = done_cnt;
        for (int i = 0; i < 8; i++) expect_wr(i, 16'h0000);
        COUNT = 4'd3; START = 1'b1; CLEAR = 1'b1; tick(); START = 1'b0; CLEAR = 1'b0;
`ifndef RAM_LOADER_VERIFY_EN
        for (int i = 0; i < 8; i++) begin
            chk("clear_consecutive_load", 32'(MEM_LOAD), 1);
            tick();
        end
        chk("clear_done_after_8", 32'(DONE), 1);
`endif
        wait_done(d0);
        chk("clear_writes", 32'(wr_cnt - w0), 8);
        chk("clear_dones", 32'(done_cnt - d0), 1);
        for (int i = 0; i < 8; i++) chk("clear_ram_zero", 32'(ram[i]), 0);

        // COUNT = 0: immediate DONE, no writes
        w0 = wr_cnt; d0 = done_cnt;
        start_load(0);
        chk("count0_done", 32'(DONE), 1);
        chk("count0_no_load", 32'(MEM_LOAD), 0);
        chk("count0_not_busy", 32'(BUSY), 0);
        tick(); tick();
        chk("count0_writes", 32'(wr_cnt - w0), 0);
        chk("count0_dones", 32'(done_cnt - d0), 1);

        // COUNT = 15 saturates to the full 8-word depth
        w0 = wr_cnt; d0 = done_cnt;
        for (int i = 0; i < 8; i++) expect_wr(i, W'(16'h0100 + i));
        start_load(4'd15);
        for (int i = 0; i < 8; i++) send(W'(16'h0100 + i));
        wait_done(d0);
        DIN_VALID = 1'b0;
        chk("count15_writes", 32'(wr_cnt - w0), 8);
        chk("count15_ready_after", 32'(DIN_READY), 0);
        chk("count15_ram7", 32'(ram[7]), 32'h0107);

        // Gapped DIN_VALID: stall in LOAD with DIN_READY held high
        w0 = wr_cnt; d0 = done_cnt;
        expect_wr(0, 16'h00B0); expect_wr(1, 16'h00B1);
        start_load(2);
        send(16'h00B0);
        DIN_VALID = 1'b0;
        tick(); tick(); tick();
        chk("gap_ready_held", 32'(DIN_READY), 1);
        chk("gap_busy", 32'(BUSY), 1);
        chk("gap_no_extra_write", 32'(wr_cnt - w0), 1);
        send(16'h00B1);
        DIN_VALID = 1'b0;
        wait_done(d0);
        chk("gap_writes", 32'(wr_cnt - w0), 2);
        chk("gap_ram1", 32'(ram[1]), 32'h00B1);

        // RESET after 2 of 5 words
        w0 = wr_cnt;
        expect_wr(0, 16'hA001); expect_wr(1, 16'hA002);
        start_load(5);
        send(16'hA001); send(16'hA002);
        DIN_VALID = 1'b0;
        tick(); tick();
        RESET = 1'b1; tick(); RESET = 1'b0;
        chk_idle_outputs("midreset");
        DIN_VALID = 1'b1; DIN = 16'hDEAD;
        repeat (4) tick();
        chk("midreset_ready_low", 32'(DIN_READY), 0);
        DIN_VALID = 1'b0;
        chk("midreset_writes", 32'(wr_cnt - w0), 2);
        chk("midreset_ram0", 32'(ram[0]), 32'hA001);
        chk("midreset_ram1", 32'(ram[1]), 32'hA002);
        chk("midreset_ram2_kept", 32'(ram[2]), 32'h0102);
        chk("midreset_queue_empty", 32'(exp_q.size()), 0);

        // Readback mismatch at address 2 (ERROR must stay 0 without verify)
        corrupt = 1'b1;
        d0 = done_cnt;
        expect_wr(0, 16'h5550); expect_wr(1, 16'h5551); expect_wr(2, 16'h5552);
        start_load(3);
        send(16'h5550); send(16'h5551); send(16'h5552);
        DIN_VALID = 1'b0;
        wait_done(d0);
`ifdef RAM_LOADER_VERIFY_EN
        chk("verify_error_set", 32'(ERROR), 1);
`else
        chk("noverify_error_zero", 32'(ERROR), 0);
`endif
        corrupt = 1'b0;
        d0 = done_cnt;
        expect_wr(0, 16'h7777);
        start_load(1);
        chk("restart_error_clear", 32'(ERROR), 0);
        send(16'h7777);
        DIN_VALID = 1'b0;
        wait_done(d0);
        chk("final_queue_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

`ifdef RAM_LOADER_VERIFY_EN
    // ERROR must persist through the DONE cycle of the corrupted load
    always @(negedge CLK) begin
        if (corrupt && DONE) chk("verify_error_at_done", 32'(ERROR), 1);
    end
`endif

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
